// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised register file with several combinational read ports,
// one synchronous write port, an optional hard-zero register 0 and a sequential
// clear engine that wipes every register after reset before raising ready.
// Optional feature macro: REG_FILE_BYPASS_EN (write-through forwarding of the
// write-port data onto any read port addressing the register being written).

module reg_file_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [AW-1:0]            wa,
  input  logic [WIDTH-1:0]         wd,
  input  logic [NUM_RD*AW-1:0]     ra,
  output logic [NUM_RD*WIDTH-1:0]  rd,
  output logic                     ready
);

  // One extra counter bit keeps the terminal compare free of wrap concerns.
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic wa_is_zero;
  logic wr_drop;
  logic wr_ok;

  // A user write is honoured only in RUN and never lands on a hard-zero register 0.
  always_comb begin
    wa_is_zero = (wa == '0);
    wr_drop    = (ZERO_REG != 0) && wa_is_zero;
    wr_ok      = (state_q == RUN) && we && !wr_drop;
  end

  // Next-state logic: walk the clear counter through every index, then settle in RUN.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + CNT_ONE;
        if (clr_cnt_q == CLR_LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        ready_d = 1'b1;
      end
    endcase
  end

  // Control registers; reset forces the clear sequence to restart from index 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Storage update: clear one entry per edge in CLEAR, user write in RUN, nothing under reset.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (rst_n) begin
      if (state_q == CLEAR) begin
        mem_d[clr_cnt_q[AW-1:0]] = '0;
      end else if (wr_ok) begin
        mem_d[wa] = wd;
      end
    end
  end

  // Register storage; reset leaves contents alone, the clear engine wipes them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Combinational read ports: zero until ready, zero for a hard-zero register 0.
  always_comb begin
    rd = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (ready_q) begin
        rd[k*WIDTH +: WIDTH] = mem_q[ra[k*AW +: AW]];
        if ((ZERO_REG != 0) && (ra[k*AW +: AW] == '0)) begin
          rd[k*WIDTH +: WIDTH] = '0;
        end
`ifdef REG_FILE_BYPASS_EN
        if (wr_ok && (ra[k*AW +: AW] == wa)) begin
          rd[k*WIDTH +: WIDTH] = wd;
        end
`endif
      end
    end
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for reg_file_mp. Instance A uses the default
// 32x32, 2-port, hard-zero configuration; instance B is 16x8 with 4 ports and an
// ordinary register 0. Stimulus pushes expected values, a negedge monitor compares.

module tb_reg_file_mp;

  localparam int AW_A = 5;
  localparam int AW_B = 4;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n_a, rst_n_b;
  logic        we_a, we_b;
  logic [4:0]  wa_a;
  logic [3:0]  wa_b;
  logic [31:0] wd_a;
  logic [7:0]  wd_b;
  logic [9:0]  ra_a;
  logic [15:0] ra_b;
  logic [63:0] rd_a;
  logic [31:0] rd_b;
  logic        ready_a, ready_b;

  int checks;
  int failures;

  typedef struct packed {
    logic [1:0]  dut;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  reg_file_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .we(we_a), .wa(wa_a), .wd(wd_a),
    .ra(ra_a), .rd(rd_a), .ready(ready_a)
  );

  reg_file_mp #(.WIDTH(8), .DEPTH(16), .NUM_RD(4), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .we(we_b), .wa(wa_b), .wd(wd_b),
    .ra(ra_b), .rd(rd_b), .ready(ready_b)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if the sequence stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d,
                               input logic [4:0] r0, input logic [4:0] r1);
    we_a = w;
    wa_a = a;
    wd_a = d;
    ra_a = {r1, r0};
  endtask

  task automatic applyStimulusB(input logic w, input logic [3:0] a, input logic [7:0] d,
                                input logic [15:0] r);
    we_b = w;
    wa_b = a;
    wd_b = d;
    ra_b = r;
  endtask

  // port = -1 selects the ready flag.
  task automatic expect_val(input logic [1:0] dut, input int port, input logic [31:0] v,
                            input string name);
    exp_t e;
    e.dut  = dut;
    e.port = port;
    e.val  = v;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic checkOutput(input exp_t e, input string name);
    logic [31:0] act;
    if (e.dut == 2'd0) begin
      if (e.port < 0) act = {31'b0, ready_a};
      else            act = rd_a[e.port*32 +: 32];
    end else begin
      if (e.port < 0) act = {31'b0, ready_b};
      else            act = {24'b0, rd_b[e.port*8 +: 8]};
    end
    checks++;
    if (act !== e.val) begin
      failures++;
      $display("[TB] FAIL %s: got %h required %h", name, act, e.val);
    end
  endtask

  // Monitor: on every falling edge drain whatever the stimulus queued for this cycle.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checkOutput(e, n);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n_a  = 1'b0;
    rst_n_b  = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd3);
    applyStimulusB(1'b0, 4'd0, 8'h0, 16'h0);

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_val(2'd0, -1, 32'd0, $sformatf("reset_ready_a_%0d", i));
      expect_val(2'd0, 0, 32'd0, $sformatf("reset_rd0_a_%0d", i));
      expect_val(2'd1, -1, 32'd0, $sformatf("reset_ready_b_%0d", i));
    end

    // Release and count clear edges; a write during the first clear cycles is ignored.
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    for (int k = 0; k <= 33; k++) begin
      if (k == 0)      applyStimulus(1'b1, 5'd3, 32'h1234, 5'd3, 5'd5);
      else if (k == 2) applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
      expect_val(2'd0, -1, (k >= 32) ? 32'd1 : 32'd0, $sformatf("clear_ready_a_k%0d", k));
      expect_val(2'd0, 0, 32'd0, $sformatf("clear_rd0_a_k%0d", k));
      if (k == 15 || k == 16)
        expect_val(2'd1, -1, (k >= 16) ? 32'd1 : 32'd0, $sformatf("clear_ready_b_k%0d", k));
      tick();
    end

    // Every register reads zero after the clear.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      expect_val(2'd0, 0, 32'd0, $sformatf("cleared_rd0_x%0d", i));
      expect_val(2'd0, 1, 32'd0, $sformatf("cleared_rd1_x%0d", 31 - i));
      tick();
    end

    // Write then read, both ports on the same address.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    expect_val(2'd0, 0, BYP ? 32'hDEADBEEF : 32'd0, "wr5_same_cycle_rd0");
    expect_val(2'd0, 1, BYP ? 32'hDEADBEEF : 32'd0, "wr5_same_cycle_rd1");
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    expect_val(2'd0, 0, 32'hDEADBEEF, "wr5_after_rd0");
    expect_val(2'd0, 1, 32'hDEADBEEF, "wr5_after_rd1");
    tick();

    // Hard-zero register: write dropped and never forwarded.
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5);
    expect_val(2'd0, 0, 32'd0, "zero_same_cycle_rd0");
    expect_val(2'd0, 1, 32'hDEADBEEF, "zero_same_cycle_rd1");
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    expect_val(2'd0, 0, 32'd0, "zero_after_rd0");
    expect_val(2'd0, 1, 32'd0, "zero_after_rd1");
    tick();

    // Top address, port 1 on an untouched neighbour.
    applyStimulus(1'b1, 5'd31, 32'h0F0F0F0F, 5'd31, 5'd30);
    expect_val(2'd0, 0, BYP ? 32'h0F0F0F0F : 32'd0, "wr31_same_cycle_rd0");
    expect_val(2'd0, 1, 32'd0, "wr31_same_cycle_rd1");
    tick();
    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 5'd31, 5'd5);
    expect_val(2'd0, 0, 32'h0F0F0F0F, "wr31_after_rd0");
    expect_val(2'd0, 1, 32'hDEADBEEF, "wr7_other_port_rd1");
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd31);
    expect_val(2'd0, 0, 32'hA5A5A5A5, "wr7_after_rd0");

    // Reset pulse in RUN: outputs still live until the edge.
    rst_n_a = 1'b0;
    expect_val(2'd0, -1, 32'd1, "pre_reset_ready");
    tick();
    rst_n_a = 1'b1;
    expect_val(2'd0, -1, 32'd0, "post_reset_ready");
    expect_val(2'd0, 0, 32'd0, "post_reset_rd0");
    for (int k = 0; k < 10; k++) begin
      expect_val(2'd0, -1, 32'd0, $sformatf("reclear_ready_k%0d", k));
      tick();
    end

    // Second reset at clear cycle 10 restarts the count.
    rst_n_a = 1'b0;
    tick();
    rst_n_a = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      if (k == 31 || k == 32)
        expect_val(2'd0, -1, (k >= 32) ? 32'd1 : 32'd0, $sformatf("restart_ready_k%0d", k));
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd31);
    expect_val(2'd0, 0, 32'd0, "restart_x7");
    expect_val(2'd0, 1, 32'd0, "restart_x31");
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd3);
    expect_val(2'd0, 0, 32'd0, "restart_x5");
    expect_val(2'd0, 1, 32'd0, "restart_x3");
    tick();

    // Instance B: register 0 is ordinary.
    applyStimulusB(1'b1, 4'd0, 8'hFF, 16'h0000);
    for (int p = 0; p < 4; p++)
      expect_val(2'd1, p, BYP ? 32'hFF : 32'h0, $sformatf("b_x0_same_cycle_p%0d", p));
    tick();
    applyStimulusB(1'b0, 4'd0, 8'h00, 16'h0000);
    for (int p = 0; p < 4; p++)
      expect_val(2'd1, p, 32'hFF, $sformatf("b_x0_after_p%0d", p));
    tick();

    // Fill x[i] = i, checking the old value (or forwarded value) on port 0.
    for (int i = 0; i < 16; i++) begin
      applyStimulusB(1'b1, 4'(i), 8'(i), {12'h000, 4'(i)});
      expect_val(2'd1, 0, BYP ? 32'(i) : ((i == 0) ? 32'hFF : 32'h0), $sformatf("b_fill_x%0d", i));
      tick();
    end

    // Multi-port reads, including duplicate addresses.
    applyStimulusB(1'b0, 4'd0, 8'h00, {4'd15, 4'd1, 4'd1, 4'd0});
    expect_val(2'd1, 0, 32'd0,  "b_mp_p0");
    expect_val(2'd1, 1, 32'd1,  "b_mp_p1");
    expect_val(2'd1, 2, 32'd1,  "b_mp_p2");
    expect_val(2'd1, 3, 32'd15, "b_mp_p3");
    tick();
    applyStimulusB(1'b0, 4'd0, 8'h00, {4'd14, 4'd13, 4'd2, 4'd9});
    expect_val(2'd1, 0, 32'd9,  "b_mp2_p0");
    expect_val(2'd1, 1, 32'd2,  "b_mp2_p1");
    expect_val(2'd1, 2, 32'd13, "b_mp2_p2");
    expect_val(2'd1, 3, 32'd14, "b_mp2_p3");
    tick();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
